// File: rtl/serial_alu_sequencer.sv
// Bit-serial ALU sequencer: AND / OR / ADD (B optionally inverted) over WIDTH cycles, LSB first, through a 1-bit slice.
// Latency: a request accepted at edge T first shows out_valid after edge T+WIDTH. Best-case throughput is one op per WIDTH+2 cycles.
// Backpressure: in_ready is high only in IDLE. The result holds in DONE until out_ready is seen; no new request is taken meanwhile.
//
// Ports:
//   clk, rst_n                 clock and synchronous active-low reset
//   in_valid/in_ready          request handshake; in_a, in_b, in_select, in_invertb, in_cin carry the request
//   out_valid/out_ready        result handshake; out_result, out_cout, out_ovf, out_zero carry the result
module serial_alu_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_select,
    input  logic             in_invertb,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic [WIDTH-1:0]  r_sh;
    logic [1:0]        sel;
    logic              inv;
    logic              carry;
    logic [CW-1:0]     cnt;

    // 1-bit slice: operates on the current LSBs of the operand shift registers.
    logic              bt;
    logic              rbit;
    logic              carry_next;
    logic [WIDTH-1:0]  res_next;

    always_comb begin
        bt         = b_sh[0] ^ (sel[1] & inv);
        rbit       = 1'b0;
        carry_next = 1'b0;
        case (sel)
            2'b00: rbit = a_sh[0] & b_sh[0];
            2'b01: rbit = a_sh[0] | b_sh[0];
            default: begin
                rbit       = a_sh[0] ^ bt ^ carry;
                carry_next = (a_sh[0] & bt) | (a_sh[0] & carry) | (bt & carry);
            end
        endcase
        // Shifting in from the MSB puts bit i at result[i] after WIDTH steps.
        res_next = {rbit, r_sh[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_cout   <= 1'b0;
            out_ovf    <= 1'b0;
            out_zero   <= 1'b0;
            a_sh       <= '0;
            b_sh       <= '0;
            r_sh       <= '0;
            sel        <= 2'b00;
            inv        <= 1'b0;
            carry      <= 1'b0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh     <= in_a;
                        b_sh     <= in_b;
                        sel      <= in_select;
                        inv      <= in_invertb;
                        carry    <= in_select[1] & in_cin;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    r_sh  <= res_next;
                    carry <= carry_next;
                    if (cnt == LAST) begin
                        // carry still holds the carry into the MSB here, so
                        // overflow is carry-in(MSB) XOR carry-out(MSB).
                        out_result <= res_next;
                        out_zero   <= (res_next == '0);
                        out_cout   <= carry_next;
                        out_ovf    <= sel[1] & (carry ^ carry_next);
                        out_valid  <= 1'b1;
                        cnt        <= '0;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu_sequencer.sv
module tb_serial_alu_sequencer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [1:0]   in_select;
    logic         in_invertb;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_cout;
    logic         out_ovf;
    logic         out_zero;

    serial_alu_sequencer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_select  (in_select),
        .in_invertb (in_invertb),
        .in_cin     (in_cin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_cout   (out_cout),
        .out_ovf    (out_ovf),
        .out_zero   (out_zero)
    );

    always #5 clk = ~clk;

    // Expected response: {result, cout, ovf, zero}
    typedef logic [W+2:0] exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic prev_v = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: latency on each rising out_valid, result contents on each handshake.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (out_valid && !prev_v) begin
                if (acc_q.size() == 0) begin
                    check("unexpected_out_valid", 32'(out_valid), 32'(0));
                end else begin
                    check("latency", 32'(cyc - acc_q.pop_front()), 32'(W));
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'(out_valid), 32'(0));
                end else begin
                    check("result_flags", 32'({out_result, out_cout, out_ovf, out_zero}), 32'(exp_q.pop_front()));
                end
            end
        end
        prev_v = out_valid;
    end

    // Presents a request and returns after the accepting edge; in_valid is left high.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] s,
                        input logic iv, input logic ci, input exp_t e, input bit track,
                        output int acc);
        int n = 0;
        acc = -1;
        @(negedge clk);
        in_a = a; in_b = b; in_select = s; in_invertb = iv; in_cin = ci;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'(1));
        end else begin
            acc = cyc + 1;
            if (track) begin
                exp_q.push_back(e);
                acc_q.push_back(acc);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        int t0, t1, t2, t3;
        int n;
        logic seen;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_select = 2'b00; in_invertb = 1'b0; in_cin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'(1));
        check("reset_outputs", 32'({out_valid, out_result, out_cout, out_ovf, out_zero}), 32'(0));
        rst_n = 1'b1;

        // Back-to-back with in_valid held high throughout.
        send(8'hFF, 8'h01, 2'b10, 1'b0, 1'b0, {8'h00, 1'b1, 1'b0, 1'b1}, 1, t0);
        send(8'h05, 8'h07, 2'b10, 1'b1, 1'b1, {8'hFE, 1'b0, 1'b0, 1'b0}, 1, t1);
        send(8'h07, 8'h05, 2'b11, 1'b1, 1'b1, {8'h02, 1'b1, 1'b0, 1'b0}, 1, t2);
        in_valid = 1'b0;
        check("b2b_spacing_1", 32'(t1 - t0), 32'(W + 2));
        check("b2b_spacing_2", 32'(t2 - t1), 32'(W + 2));
        drain();

        // Backpressure: result held, no accept while in_valid stays high.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(8'h7F, 8'h01, 2'b10, 1'b0, 1'b0, {8'h80, 1'b0, 1'b1, 1'b0}, 1, t3);
        in_a = 8'hAA; in_b = 8'h55; in_select = 2'b01;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_out_valid_rise", 32'(out_valid), 32'(1));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold", 32'({out_valid, out_result, out_cout, out_ovf, in_ready}), 32'({1'b1, 8'h80, 1'b0, 1'b1, 1'b0}));
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_idle", 32'({out_valid, in_ready}), 32'({1'b0, 1'b1}));
        drain();

        send(8'h80, 8'h80, 2'b10, 1'b0, 1'b0, {8'h00, 1'b1, 1'b1, 1'b1}, 1, t0);
        in_valid = 1'b0;
        send(8'hF0, 8'h3C, 2'b00, 1'b1, 1'b1, {8'h30, 1'b0, 1'b0, 1'b0}, 1, t0);
        in_valid = 1'b0;
        send(8'hF0, 8'h3C, 2'b01, 1'b1, 1'b1, {8'hFC, 1'b0, 1'b0, 1'b0}, 1, t0);
        in_valid = 1'b0;
        send(8'h00, 8'h00, 2'b01, 1'b1, 1'b1, {8'h00, 1'b0, 1'b0, 1'b1}, 1, t0);
        in_valid = 1'b0;
        drain();

        // Reset at bit 4 of an ADD, with in_valid high across the reset edge.
        send(8'hFF, 8'hFF, 2'b10, 1'b0, 1'b1, '0, 0, t0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrun_reset_outputs", 32'({out_valid, out_result, out_cout, out_ovf, out_zero}), 32'(0));
        check("midrun_reset_no_accept", 32'(in_ready), 32'(1));
        rst_n = 1'b1;
        in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        check("no_partial_result", 32'(seen), 32'(0));
        send(8'h01, 8'h01, 2'b10, 1'b0, 1'b0, {8'h02, 1'b0, 1'b0, 1'b0}, 1, t0);
        in_valid = 1'b0;
        drain();

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
